// File: rtl/mmu_dma_wrr_sched_pkg.sv
// Shared types and constants for the weighted round-robin DMA request scheduler.
package mmu_dma_wrr_sched_pkg;
  localparam int MAX_OUTSTANDING_DEF = 8;
  localparam int CREDIT_W            = 8;
  // Captured-request storage is sized for the widest supported instance.
  localparam int REQ_ADDR_W          = 64;
  localparam int REQ_LEN_W           = 28;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] paddr;
    logic [REQ_LEN_W-1:0]  len;
    logic                  last;
  } sched_req_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } sched_state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mmu_dma_wrr_sched_if.sv
// Region request, downstream DMA request and data-mux ordering channels.
interface mmu_dma_wrr_sched_if
  import mmu_dma_wrr_sched_pkg::*;
#(
  parameter int N_REGIONS = 4,
  parameter int ADDR_BITS = 64,
  parameter int LEN_BITS  = 28
) ();
  localparam int ID_W = id_width(N_REGIONS);

  logic [N_REGIONS-1:0]           s_req_valid;
  logic [N_REGIONS-1:0]           s_req_ready;
  logic [N_REGIONS*ADDR_BITS-1:0] s_req_paddr;
  logic [N_REGIONS*LEN_BITS-1:0]  s_req_len;
  logic [N_REGIONS-1:0]           s_req_last;

  logic                           m_req_valid;
  logic                           m_req_ready;
  logic [ADDR_BITS-1:0]           m_req_paddr;
  logic [LEN_BITS-1:0]            m_req_len;
  logic                           m_req_last;

  logic                           m_mux_valid;
  logic                           m_mux_ready;
  logic [ID_W-1:0]                m_mux_vfid;
  logic [LEN_BITS-1:0]            m_mux_len;

  // master: the scheduler; slave: the regions plus the host channel around it
  modport master (
    input  s_req_valid, s_req_paddr, s_req_len, s_req_last, m_req_ready, m_mux_ready,
    output s_req_ready, m_req_valid, m_req_paddr, m_req_len, m_req_last,
           m_mux_valid, m_mux_vfid, m_mux_len
  );

  modport slave (
    output s_req_valid, s_req_paddr, s_req_len, s_req_last, m_req_ready, m_mux_ready,
    input  s_req_ready, m_req_valid, m_req_paddr, m_req_len, m_req_last,
           m_mux_valid, m_mux_vfid, m_mux_len
  );
endinterface

// File: rtl/mmu_dma_wrr_sched_rr_pick.sv
// Rotating priority picker: first set bit at or above start, wrapping to the lowest.
module mmu_rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    eligible,
  input  logic [ID_W-1:0] start,
  output logic [ID_W-1:0] winner,
  output logic            found
);
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
    // A hit at or past the pointer overrides the wrapped candidate.
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i] && (ID_W'(i) >= start)) winner = ID_W'(i);
    end
  end
endmodule

// File: rtl/mmu_dma_wrr_sched.sv
// Weighted round-robin sharing of one DMA request channel between MMU regions,
// with per-region outstanding credits and a matching data-mux ordering entry.
module mmu_dma_wrr_sched
  import mmu_dma_wrr_sched_pkg::*;
#(
  parameter int N_REGIONS       = 4,
  parameter int ADDR_BITS       = 64,
  parameter int LEN_BITS        = 28,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int WGT_BITS        = 4
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            sched_en,
  input  logic [N_REGIONS*WGT_BITS-1:0]   weight,
  mmu_dma_wrr_sched_if.master             bus,
  input  logic [N_REGIONS-1:0]            xfer_done,
  output logic [N_REGIONS*CREDIT_W-1:0]   outstanding,
  output logic [N_REGIONS-1:0]            err_underflow
);
  localparam int                  ID_W    = id_width(N_REGIONS);
  localparam logic [CREDIT_W-1:0] CAP     = CREDIT_W'(MAX_OUTSTANDING);
  localparam logic [ID_W-1:0]     LAST_ID = ID_W'(N_REGIONS - 1);

  sched_state_t         state;
  logic [ID_W-1:0]      cur, rr_ptr, pick_idx, winner, next_ptr;
  logic [WGT_BITS-1:0]  burst_cnt, cur_wgt, eff_wgt;
  logic [N_REGIONS-1:0] eligible, sel;
  logic                 pick_found, keep_cur, grant, req_vld, mux_vld;
  sched_req_t           req_q;
  logic [CREDIT_W-1:0]  cnt [N_REGIONS];

  always_comb begin
    for (int r = 0; r < N_REGIONS; r++)
      eligible[r] = bus.s_req_valid[r] & (cnt[r] < CAP) & sched_en;
  end

  // The current owner keeps the channel until its quota is spent.
  assign cur_wgt  = weight[int'(cur)*WGT_BITS +: WGT_BITS];
  assign eff_wgt  = (cur_wgt == '0) ? WGT_BITS'(1) : cur_wgt;
  assign keep_cur = eligible[cur] & (burst_cnt < eff_wgt);

  mmu_rr_pick #(.N(N_REGIONS), .ID_W(ID_W)) u_pick (
    .eligible (eligible),
    .start    (rr_ptr),
    .winner   (pick_idx),
    .found    (pick_found)
  );

  assign winner   = keep_cur ? cur : pick_idx;
  assign grant    = (state == S_IDLE) & ~areset & (keep_cur | pick_found);
  assign next_ptr = (winner == LAST_ID) ? '0 : winner + 1'b1;

  always_comb begin
    sel         = '0;
    sel[winner] = grant;
  end
  assign bus.s_req_ready = sel;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= S_IDLE;
      cur       <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      req_vld   <= 1'b0;
      mux_vld   <= 1'b0;
      req_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            req_q <= '{paddr: REQ_ADDR_W'(bus.s_req_paddr[int'(winner)*ADDR_BITS +: ADDR_BITS]),
                       len:   REQ_LEN_W'(bus.s_req_len[int'(winner)*LEN_BITS +: LEN_BITS]),
                       last:  bus.s_req_last[winner]};
            if (winner == cur)
              burst_cnt <= (burst_cnt == '1) ? burst_cnt : burst_cnt + 1'b1;
            else
              burst_cnt <= WGT_BITS'(1);
            cur     <= winner;
            rr_ptr  <= next_ptr;
            req_vld <= 1'b1;
            mux_vld <= 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          req_vld <= req_vld & ~bus.m_req_ready;
          mux_vld <= mux_vld & ~bus.m_mux_ready;
          if ((~req_vld | bus.m_req_ready) & (~mux_vld | bus.m_mux_ready))
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Credits: a capture and a completion on the same region cancel out.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int r = 0; r < N_REGIONS; r++) cnt[r] <= '0;
      err_underflow <= '0;
    end else begin
      for (int r = 0; r < N_REGIONS; r++) begin
        if (sel[r] & ~xfer_done[r]) begin
          cnt[r] <= cnt[r] + 1'b1;
        end else if (~sel[r] & xfer_done[r]) begin
          if (cnt[r] == '0) err_underflow[r] <= 1'b1;
          else              cnt[r]           <= cnt[r] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < N_REGIONS; r++)
      outstanding[r*CREDIT_W +: CREDIT_W] = cnt[r];
  end

  assign bus.m_req_valid = req_vld;
  assign bus.m_req_paddr = req_q.paddr[ADDR_BITS-1:0];
  assign bus.m_req_len   = req_q.len[LEN_BITS-1:0];
  assign bus.m_req_last  = req_q.last;
  assign bus.m_mux_valid = mux_vld;
  assign bus.m_mux_vfid  = cur;
  assign bus.m_mux_len   = req_q.len[LEN_BITS-1:0];
endmodule

// File: doc/mmu_dma_wrr_sched.md
Name: mmu_dma_wrr_sched

Overview:
Weighted round-robin scheduler that shares one host DMA request channel between the per-region MMU request streams. It enforces a per-region cap on outstanding requests using credits returned by completion pulses. For every issued request it emits a matching ordering entry that steers the data mux. It sits between the region MMUs and the host XDMA channel, on both the read and write sides, with one instance per direction.

Parameters:
N_REGIONS, 4, number of requesting regions (1..16)
ADDR_BITS, 64, physical address width
LEN_BITS, 28, transfer length width
MAX_OUTSTANDING, 8, max in-flight requests per region (1..255)
WGT_BITS, 4, width of per-region weight

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
sched_en  in  1  global enable; when low, no new grants are made
weight  in  N_REGIONS*WGT_BITS  consecutive-grant quota per region; 0 is treated as 1
s_req_valid  in  N_REGIONS  per-region request valid
s_req_ready  out  N_REGIONS  per-region request accept; one-hot or zero
s_req_paddr  in  N_REGIONS*ADDR_BITS  request address
s_req_len  in  N_REGIONS*LEN_BITS  request length
s_req_last  in  N_REGIONS  last-of-transfer flag
m_req_valid  out  1  downstream DMA request valid
m_req_ready  in  1  downstream accept
m_req_paddr  out  ADDR_BITS  issued address
m_req_len  out  LEN_BITS  issued length
m_req_last  out  1  issued last flag
m_mux_valid  out  1  ordering entry valid
m_mux_ready  in  1  ordering accept
m_mux_vfid  out  clog2(N_REGIONS)  region that owns the issued request
m_mux_len  out  LEN_BITS  issued length, copied for the data mux
xfer_done  in  N_REGIONS  per-region completion pulse; returns one credit
outstanding  out  N_REGIONS*8  per-region in-flight count
err_underflow  out  N_REGIONS  sticky flag: completion received with zero outstanding

Behaviour:
- Reset (async, areset=1): state IDLE, all valid/ready outputs 0, counters 0, err_underflow 0, rr_ptr=0, burst_cnt=0, data registers 0.
- Eligibility of region r: s_req_valid[r] & (outstanding[r] < MAX_OUTSTANDING) & sched_en.
- FSM IDLE:
  - Winner selection:
    - If cur is eligible and burst_cnt < eff_weight[cur], the winner is cur.
    - Otherwise the winner is the first eligible region searching from rr_ptr upward, with wrap. burst_cnt resets to 0 when the winner changes.
  - When a winner w exists, s_req_ready[w]=1 combinationally for exactly that cycle. The request is captured into output registers.
  - On capture: cur=w, burst_cnt++, outstanding[w]++, rr_ptr=(w+1) mod N_REGIONS. Go to ISSUE.
- FSM ISSUE:
  - m_req_valid and m_mux_valid are asserted from the cycle after capture. Data stays stable while valid.
  - Each valid drops independently on its own handshake.
  - When both have completed (same cycle or different cycles), go to IDLE on the next edge.
  - No s_req_ready is asserted in ISSUE.
- Throughput: at most 1 request per 2 cycles. Grant-to-valid latency is 1 cycle.
- Credits:
  - Increment on capture, decrement on xfer_done[r].
  - Simultaneous increment and decrement on the same region leaves the count unchanged.
  - xfer_done[r] with count 0 and no simultaneous capture: count stays 0, err_underflow[r] is set (sticky until reset).
- Counter width: 8 bits, never exceeds MAX_OUTSTANDING, because the region is ineligible when at the cap.
- Weight is sampled every IDLE cycle, so a change takes effect at the next grant decision.
- sched_en dropping during ISSUE does not abort the in-flight issue. It only blocks the next grant.
- s_req_valid dropping without a grant is permitted and has no effect on state.

Decomposition:
- Shared package (lynxTypes): constants for the default MAX_OUTSTANDING and the credit counter width (8), plus a typedef sched_req_t {paddr, len, last} used for the captured request register.
- Sub-module mmu_rr_pick: combinational priority picker, inputs eligible vector and start pointer, outputs winner index and found flag. It is reused by any future region arbiter.

Test Plan:
- N=4, weight={1,1,1,1}, all regions valid, downstream always ready -> grants in order 0,1,2,3,0; m_mux_vfid matches; one grant every 2 cycles.
- weight[0]=3, others 1, all valid -> grant order 0,0,0,1,2,3,0,0,0.
- MAX_OUTSTANDING=2, only region 1 valid, no xfer_done -> exactly 2 grants, then s_req_ready stays 0; pulse xfer_done[1] -> one more grant; outstanding[1] reads 2.
- m_req_ready held low for 5 cycles, m_mux_ready=1 -> m_mux_valid drops after 1 cycle, m_req_valid is held with stable paddr=0x1000 and len=0x40; return to IDLE only after m_req handshake.
- xfer_done[2] pulsed with outstanding[2]=0 -> err_underflow[2]=1, count stays 0; a capture and xfer_done on region 3 in the same cycle -> outstanding[3] unchanged.
- areset asserted during ISSUE -> same-cycle (async) clear: all valid outputs 0, counters 0; after release, the first grant goes to region 0.
